// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encodings, frame line levels, default divider and parity helper.
// Used by both the TX engine and the RX side.
package uart_pkg;

  localparam int DEF_BAUD_DIV = 10417;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

  // Bit 7 only contributes in 8-bit mode; odd parity is the inverse of even.
  function automatic logic parity_bit(input logic [7:0] d, input logic eight, input logic odd);
    return (^d[6:0]) ^ (d[7] & eight) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// Host-side handshake and serial line of the UART transmitter.
interface uart_tx_engine_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       eight;
  logic       pen;
  logic       ohel;
  logic       tx;
  logic       tx_rdy;
  logic       tx_done;

  modport master (
    output tx_data, tx_start, eight, pen, ohel,
    input  tx, tx_rdy, tx_done
  );

  modport slave (
    input  tx_data, tx_start, eight, pen, ohel,
    output tx, tx_rdy, tx_done
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period timer: one-cycle tick whenever the count reaches BAUD_DIV-1, then wraps.
// A synchronous clear restarts the period so a bit begins exactly at acceptance.
module uart_baud_tick #(
  parameter int BAUD_DIV = 10417,
  parameter int CNT_W    = 14
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  logic [CNT_W-1:0] cnt_reg;

  assign tick = (cnt_reg == CNT_W'(BAUD_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clr || tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: start bit, 7/8 data bits LSB-first, optional parity, stop bit(s).
// Define UART_TX_TWO_STOP_EN to send two stop bits instead of one.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = DEF_BAUD_DIV,
  parameter int CNT_W    = 14
) (
  input logic             clk,
  input logic             rst,
  uart_tx_engine_if.slave bus
);

  logic [2:0] state_reg;
  logic [7:0] shift_reg;
  logic [2:0] bit_idx_reg;
  logic       eight_reg;
  logic       pen_reg;
  logic       parity_reg;
  logic       tx_reg;
  logic       rdy_reg;
  logic       done_reg;

  logic       tick;
  logic       accept;
  logic       stop_last;
  logic [7:0] data_masked;
  logic [2:0] last_idx;

  assign accept   = bus.tx_start && rdy_reg;
  assign last_idx = eight_reg ? 3'd7 : 3'd6;

  // Bit 7 is forced to zero in 7-bit mode so it never reaches the line or parity.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_mask
      if (gi == 7) begin : g_msb
        assign data_masked[gi] = bus.tx_data[gi] & bus.eight;
      end else begin : g_lsb
        assign data_masked[gi] = bus.tx_data[gi];
      end
    end
  endgenerate

  uart_baud_tick #(
    .BAUD_DIV (BAUD_DIV),
    .CNT_W    (CNT_W)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .tick (tick)
  );

`ifdef UART_TX_TWO_STOP_EN
  logic stop2_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stop2_reg <= 1'b0;
    end else if (state_reg != STOP) begin
      stop2_reg <= 1'b0;
    end else if (tick) begin
      stop2_reg <= 1'b1;
    end
  end

  assign stop_last = stop2_reg;
`else
  assign stop_last = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_idx_reg <= '0;
      eight_reg   <= 1'b0;
      pen_reg     <= 1'b0;
      parity_reg  <= 1'b0;
      tx_reg      <= IDLE_LVL;
      rdy_reg     <= 1'b1;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            shift_reg  <= data_masked;
            eight_reg  <= bus.eight;
            pen_reg    <= bus.pen;
            parity_reg <= parity_bit(data_masked, bus.eight, bus.ohel);
            tx_reg     <= START_BIT;
            rdy_reg    <= 1'b0;
            state_reg  <= START;
          end
        end
        START: begin
          if (tick) begin
            tx_reg      <= shift_reg[0];
            bit_idx_reg <= '0;
            state_reg   <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx_reg == last_idx) begin
              tx_reg    <= pen_reg ? parity_reg : STOP_BIT;
              state_reg <= pen_reg ? PARITY : STOP;
            end else begin
              shift_reg   <= {1'b0, shift_reg[7:1]};
              tx_reg      <= shift_reg[1];
              bit_idx_reg <= bit_idx_reg + 1'b1;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            tx_reg    <= STOP_BIT;
            state_reg <= STOP;
          end
        end
        STOP: begin
          if (tick && stop_last) begin
            tx_reg    <= IDLE_LVL;
            rdy_reg   <= 1'b1;
            done_reg  <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: begin
          tx_reg    <= IDLE_LVL;
          rdy_reg   <= 1'b1;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.tx      = tx_reg;
  assign bus.tx_rdy  = rdy_reg;
  assign bus.tx_done = done_reg;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine at BAUD_DIV=4: stimulus queues expected line
// sequences, a monitor checks every bit period and the completion pulse.
module tb_uart_tx_engine;

  localparam int BD = 4;

  typedef struct {
    logic [15:0] bits;
    int          n;
  } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_tx_engine_if bus ();

  uart_tx_engine #(
    .BAUD_DIV (BD),
    .CNT_W    (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  frame_t exp_q[$];
  int total    = 0;
  int bad      = 0;
  int done_cnt = 0;
  int frame_no = 0;

  task automatic check(input logic ok, input string name, input string detail);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  function automatic string stops(input string s);
`ifdef UART_TX_TWO_STOP_EN
    return {s, "1"};
`else
    return s;
`endif
  endfunction

  task automatic push_frame(input string s);
    frame_t f;
    f.bits = '0;
    f.n    = s.len();
    for (int i = 0; i < s.len(); i++) f.bits[i] = (s.getc(i) == "1");
    exp_q.push_back(f);
  endtask

  task automatic drive(input logic [7:0] d, input logic e, input logic p, input logic o);
    bus.tx_data  = d;
    bus.eight    = e;
    bus.pen      = p;
    bus.ohel     = o;
    bus.tx_start = 1'b1;
  endtask

  task automatic send(input logic [7:0] d, input logic e, input logic p, input logic o,
                      input string s);
    int n = 0;
    @(negedge clk);
    while (bus.tx_rdy !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check(1'b0, "rdy_timeout", "tx_rdy never rose within 200 cycles");
    drive(d, e, p, o);
    push_frame(s);
    @(posedge clk);
    #1 bus.tx_start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (bus.tx_done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check(1'b0, "done_timeout", "tx_done never pulsed within 200 cycles");
  endtask

  // Monitor: a falling tx_rdy marks acceptance; that negedge is the first start-bit sample.
  initial begin
    frame_t     f;
    logic       prev_rdy;
    logic       aborted;
    logic       busy_bad;
    logic [3:0] smp;
    prev_rdy = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_rdy = 1'b1;
      end else begin
        if (prev_rdy && bus.tx_rdy === 1'b0) begin
          frame_no++;
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_frame", $sformatf("frame %0d accepted with nothing queued", frame_no));
          end else begin
            f        = exp_q.pop_front();
            aborted  = 1'b0;
            busy_bad = 1'b0;
            for (int b = 0; b < f.n && !aborted; b++) begin
              smp = '0;
              for (int s = 0; s < BD; s++) begin
                if (b != 0 || s != 0) @(negedge clk);
                if (rst) begin
                  aborted = 1'b1;
                  break;
                end
                smp[s] = bus.tx;
                if (bus.tx_rdy !== 1'b0 || bus.tx_done !== 1'b0) busy_bad = 1'b1;
              end
              if (!aborted)
                check(smp === {BD{f.bits[b]}}, $sformatf("frame%0d_bit%0d", frame_no, b),
                      $sformatf("line samples %b, required %b", smp, {BD{f.bits[b]}}));
            end
            if (!aborted) begin
              check(!busy_bad, $sformatf("frame%0d_busy", frame_no),
                    "tx_rdy/tx_done not both low throughout the frame");
              @(negedge clk);
              check(bus.tx_done === 1'b1 && bus.tx_rdy === 1'b1 && bus.tx === 1'b1,
                    $sformatf("frame%0d_done", frame_no),
                    $sformatf("tx_done=%b tx_rdy=%b tx=%b, required 1 1 1",
                              bus.tx_done, bus.tx_rdy, bus.tx));
            end
          end
        end
        prev_rdy = rst ? 1'b1 : bus.tx_rdy;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.tx_done === 1'b1) done_cnt++;
    end
  end

  initial begin
    bus.tx_data  = 8'h00;
    bus.tx_start = 1'b0;
    bus.eight    = 1'b1;
    bus.pen      = 1'b0;
    bus.ohel     = 1'b0;
    rst          = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check(bus.tx === 1'b1 && bus.tx_rdy === 1'b1 && bus.tx_done === 1'b0,
            $sformatf("reset_idle_%0d", i),
            $sformatf("tx=%b tx_rdy=%b tx_done=%b, required 1 1 0", bus.tx, bus.tx_rdy, bus.tx_done));
    end

    send(8'hA5, 1'b1, 1'b0, 1'b0, stops("0101001011"));
    wait_done();

    send(8'hC3, 1'b0, 1'b1, 1'b0, stops("0110000111"));
    wait_done();

    // 8-bit odd parity, second frame requested on the tx_done cycle.
    send(8'h00, 1'b1, 1'b1, 1'b1, stops("00000000011"));
    wait_done();
    drive(8'hFF, 1'b1, 1'b1, 1'b1);
    push_frame(stops("01111111111"));
    @(posedge clk);
    #1 bus.tx_start = 1'b0;
    repeat (8) @(posedge clk);
    #1 drive(8'h81, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 bus.tx_start = 1'b0;
    wait_done();

    // Abort during data bit 3 of 8'h5A.
    send(8'h5A, 1'b1, 1'b0, 1'b0, stops("0010110101"));
    repeat (16) @(posedge clk);
    #2 rst = 1'b1;
    #1 check(bus.tx === 1'b1 && bus.tx_rdy === 1'b1 && bus.tx_done === 1'b0, "async_reset",
             $sformatf("tx=%b tx_rdy=%b tx_done=%b, required 1 1 0", bus.tx, bus.tx_rdy, bus.tx_done));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    send(8'h5A, 1'b1, 1'b0, 1'b0, stops("0010110101"));
    wait_done();

    send(8'h3C, 1'b1, 1'b0, 1'b0, stops("0001111001"));
    wait_done();

    repeat (4) @(negedge clk);
    check(exp_q.size() == 0, "queue_empty", $sformatf("%0d frames never sent, required 0", exp_q.size()));
    check(done_cnt == 6, "done_count", $sformatf("%0d tx_done pulses, required 6", done_cnt));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
